// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_pkg
// Description : Shared definitions for the DMA IO bus initiator: op codes,
//               FSM state encoding, IO register addresses and the RMW helper.
// Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

    localparam int ADR_W  = 14;
    localparam int DATA_W = 32;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_SET = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADR  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WB      = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [ADR_W-1:0] SYS_LED_IO   = 14'h3F80;
    localparam logic [ADR_W-1:0] SYS_GPI_IN   = 14'h3F81;
    localparam logic [ADR_W-1:0] SYS_GPIO_OUT = 14'h3F84;
    localparam logic [ADR_W-1:0] SYS_GPIO_IN  = 14'h3F85;
    localparam logic [ADR_W-1:0] SYS_GPIO_EN  = 14'h3F86;

    // Modified value for the write-back half of a bit-set / bit-clear.
    function automatic logic [DATA_W-1:0] rmw_value(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] mask
    );
        if (op == OP_SET) begin
            return old_val | mask;
        end
        return old_val & ~mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_master
// Description : Single-beat initiator for the word-addressed DMA IO bus.
//               Handles write, read, and atomic bit-set / bit-clear (RMW).
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_master
    import io_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADR_W-1:0]  req_adr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              dma_io_we,
    output logic [ADR_W-1:0]  dma_io_wadr,
    output logic [DATA_W-1:0] dma_io_wdata,
    output logic [ADR_W-1:0]  dma_io_radr,
    output logic              dma_io_radr_en,
    input  logic [DATA_W-1:0] dma_io_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [ADR_W-1:0]    r_adr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_accept;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RSP);
    assign w_accept  = req_valid & req_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing for one bus transaction.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (req_op == OP_WR) ? ST_WR : ST_RD_ADR;
                end
            end
            ST_WR:      w_next = ST_RSP;
            ST_RD_ADR:  w_next = ST_RD_DATA;
            ST_RD_DATA: w_next = (r_op == OP_RD) ? ST_RSP : ST_WB;
            ST_WB:      w_next = ST_RSP;
            ST_RSP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Request capture and registered bus outputs; strobes are loaded one
    // cycle ahead so they line up with the WR / RD_ADR / WB states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op           <= OP_WR;
            r_adr          <= '0;
            r_wdata        <= '0;
            rsp_rdata      <= '0;
            dma_io_we      <= 1'b0;
            dma_io_wadr    <= '0;
            dma_io_wdata   <= '0;
            dma_io_radr    <= '0;
            dma_io_radr_en <= 1'b0;
        end else begin
            dma_io_we      <= 1'b0;
            dma_io_radr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_adr   <= req_adr;
                        r_wdata <= req_wdata;
                        if (req_op == OP_WR) begin
                            dma_io_we    <= 1'b1;
                            dma_io_wadr  <= req_adr;
                            dma_io_wdata <= req_wdata;
                        end else begin
                            dma_io_radr_en <= 1'b1;
                            dma_io_radr    <= req_adr;
                        end
                    end
                end
                ST_WR: begin
                    rsp_rdata <= '0;
                end
                ST_RD_DATA: begin
                    rsp_rdata <= dma_io_rdata;
                    if (r_op != OP_RD) begin
                        // Modify from the live bus data: it is the value
                        // being captured into rsp_rdata this same cycle.
                        dma_io_we    <= 1'b1;
                        dma_io_wadr  <= r_adr;
                        dma_io_wdata <= rmw_value(r_op, dma_io_rdata, r_wdata);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
